// File: rtl/t01_next_piece_gen.sv
// Next-piece generator: 7-bag randomizer fed by a free-running LFSR, with the
// pending piece rendered as a 4x4 grid of 3-bit colours and handed off by req/ack.
module t01_next_piece_gen #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned MAX_RETRY = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        piece_req,
    output logic        piece_ack,
    output logic [2:0]  piece_type,
    output logic        next_valid,
    output logic [2:0]  next_type,
    output logic [47:0] next_block_data
);
    // An all-zero seed would lock the LFSR, so substitute the default.
    localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [3:0]  RETRY_LAST = 4'(MAX_RETRY - 1);

    typedef enum logic {GEN, READY} state_t;

    state_t      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [6:0]  used_q;
    logic [6:0]  used_d;
    logic [3:0]  retry_q;
    logic        piece_ack_q;
    logic [2:0]  piece_type_q;
    logic        next_valid_q;
    logic [2:0]  next_type_q;
    logic [47:0] next_block_data_q;

    logic [2:0]  cand;
    logic [7:0]  used_ext;
    logic        cand_ok;
    logic        accept;
    logic [2:0]  lowest;
    logic [2:0]  sel;
    logic [6:0]  used_set;
    logic [15:0] sel_mask;
    logic [2:0]  sel_colour;
    logic [47:0] sel_grid;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Index 7 maps onto a permanently "used" slot so it is always rejected.
    assign cand     = lfsr_q[2:0];
    assign used_ext = {1'b1, used_q};
    assign cand_ok  = ~used_ext[cand];
    assign accept   = cand_ok || (retry_q == RETRY_LAST);

    always_comb begin
        lowest = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!used_q[i]) begin
                lowest = 3'(i);
            end
        end
    end

    assign sel      = cand_ok ? cand : lowest;
    assign used_set = used_q | 7'(1 << sel);
    assign used_d   = (used_set == 7'h7F) ? 7'h00 : used_set;

    always_comb begin
        sel_mask   = 16'h0000;
        sel_colour = 3'b000;
        case (sel)
            3'd0: begin sel_mask = 16'h00F0; sel_colour = 3'b011; end
            3'd1: begin sel_mask = 16'h0660; sel_colour = 3'b110; end
            3'd2: begin sel_mask = 16'h0720; sel_colour = 3'b101; end
            3'd3: begin sel_mask = 16'h0360; sel_colour = 3'b010; end
            3'd4: begin sel_mask = 16'h0630; sel_colour = 3'b100; end
            3'd5: begin sel_mask = 16'h0710; sel_colour = 3'b001; end
            3'd6: begin sel_mask = 16'h0740; sel_colour = 3'b111; end
            default: begin sel_mask = 16'h0000; sel_colour = 3'b000; end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_cell
            assign sel_grid[gi*3 +: 3] = sel_mask[gi] ? sel_colour : 3'b000;
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q           <= GEN;
            lfsr_q            <= SEED_EFF;
            used_q            <= 7'h00;
            retry_q           <= 4'd0;
            piece_ack_q       <= 1'b0;
            piece_type_q      <= 3'd0;
            next_valid_q      <= 1'b0;
            next_type_q       <= 3'd0;
            next_block_data_q <= 48'd0;
        end else begin
            lfsr_q      <= lfsr_d;
            piece_ack_q <= 1'b0;
            case (state_q)
                GEN: begin
                    if (accept) begin
                        next_type_q       <= sel;
                        next_block_data_q <= sel_grid;
                        next_valid_q      <= 1'b1;
                        used_q            <= used_d;
                        retry_q           <= 4'd0;
                        state_q           <= READY;
                    end else begin
                        retry_q <= retry_q + 4'd1;
                    end
                end
                READY: begin
                    if (piece_req) begin
                        piece_type_q <= next_type_q;
                        piece_ack_q  <= 1'b1;
                        next_valid_q <= 1'b0;
                        state_q      <= GEN;
                    end
                end
                default: state_q <= GEN;
            endcase
        end
    end

    assign piece_ack       = piece_ack_q;
    assign piece_type      = piece_type_q;
    assign next_valid      = next_valid_q;
    assign next_type       = next_type_q;
    assign next_block_data = next_block_data_q;

endmodule

// File: tb/tb_t01_next_piece_gen.sv
// Directed bench for t01_next_piece_gen: reset, grid encoding, bag permutation,
// fallback, held requests and asynchronous reset mid-draw.
module tb_t01_next_piece_gen;
    localparam int MR = 8;

    logic        clk       = 1'b0;
    logic        n_rst     = 1'b0;
    logic        piece_req = 1'b0;
    logic        fb_req    = 1'b0;

    logic        piece_ack;
    logic [2:0]  piece_type;
    logic        next_valid;
    logic [2:0]  next_type;
    logic [47:0] next_block_data;

    logic        fb_ack;
    logic [2:0]  fb_type;
    logic        fb_valid;
    logic [2:0]  fb_ntype;
    logic [47:0] fb_grid;

    t01_next_piece_gen #(.SEED(16'hACE1), .MAX_RETRY(MR)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .piece_req       (piece_req),
        .piece_ack       (piece_ack),
        .piece_type      (piece_type),
        .next_valid      (next_valid),
        .next_type       (next_type),
        .next_block_data (next_block_data)
    );

    // Seed 0x0007 gives an invalid first candidate, exercising the fallback.
    t01_next_piece_gen #(.SEED(16'h0007), .MAX_RETRY(1)) u_fb (
        .clk             (clk),
        .n_rst           (n_rst),
        .piece_req       (fb_req),
        .piece_ack       (fb_ack),
        .piece_type      (fb_type),
        .next_valid      (fb_valid),
        .next_type       (fb_ntype),
        .next_block_data (fb_grid)
    );

    always #5 clk = ~clk;

    logic [15:0] sh_lfsr;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) sh_lfsr <= 16'hACE1;
        else        sh_lfsr <= {sh_lfsr[14:0], sh_lfsr[15] ^ sh_lfsr[13] ^ sh_lfsr[12] ^ sh_lfsr[10]};
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [6:0]  m_used;
    logic [3:0]  m_retry;
    logic [2:0]  m_last;
    logic [47:0] m_grid;
    logic [6:0]  seen;

    function automatic logic [47:0] grid_of(input logic [2:0] t);
        logic [15:0] mask;
        logic [2:0]  col;
        logic [47:0] g;
        case (t)
            3'd0: begin mask = 16'h00F0; col = 3'b011; end
            3'd1: begin mask = 16'h0660; col = 3'b110; end
            3'd2: begin mask = 16'h0720; col = 3'b101; end
            3'd3: begin mask = 16'h0360; col = 3'b010; end
            3'd4: begin mask = 16'h0630; col = 3'b100; end
            3'd5: begin mask = 16'h0710; col = 3'b001; end
            3'd6: begin mask = 16'h0740; col = 3'b111; end
            default: begin mask = 16'h0000; col = 3'b000; end
        endcase
        g = 48'd0;
        for (int k = 0; k < 16; k++) begin
            if (mask[k]) g[k*3 +: 3] = col;
        end
        return g;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_used  = 7'h00;
        m_retry = 4'd0;
        m_last  = 3'd0;
        m_grid  = 48'd0;
    endtask

    // Entered at a negedge with the DUT in GEN; returns at the negedge after the accept.
    task automatic do_draw(input string tag);
        logic [2:0] cand;
        logic [2:0] sel;
        bit         acc;
        int         lo;
        acc = 1'b0;
        sel = 3'd0;
        for (int a = 0; a < MR && !acc; a++) begin
            cand = sh_lfsr[2:0];
            if (cand != 3'd7 && !m_used[cand]) begin
                sel = cand;
                acc = 1'b1;
            end else if (m_retry == 4'(MR - 1)) begin
                lo = 0;
                for (int i = 6; i >= 0; i--) if (!m_used[i]) lo = i;
                sel = 3'(lo);
                acc = 1'b1;
            end else begin
                m_retry++;
            end
            @(negedge clk);
            if (!acc) begin
                chk({tag, "_gen_valid"}, next_valid, 48'd0);
                chk({tag, "_gen_ack"}, piece_ack, 48'd0);
                chk({tag, "_gen_hold"}, next_block_data, m_grid);
            end
        end
        chk({tag, "_valid"}, next_valid, 48'd1);
        chk({tag, "_type"}, next_type, sel);
        chk({tag, "_grid"}, next_block_data, grid_of(sel));
        chk({tag, "_noack"}, piece_ack, 48'd0);
        m_used = m_used | 7'(1 << sel);
        if (m_used == 7'h7F) m_used = 7'h00;
        m_retry = 4'd0;
        m_last  = sel;
        m_grid  = grid_of(sel);
    endtask

    // Entered at a negedge with the DUT in READY.
    task automatic do_request(input bit hold, input string tag);
        piece_req = 1'b1;
        @(negedge clk);
        chk({tag, "_ack"}, piece_ack, 48'd1);
        chk({tag, "_ptype"}, piece_type, m_last);
        chk({tag, "_vdrop"}, next_valid, 48'd0);
        chk({tag, "_ackhold"}, next_block_data, m_grid);
        if (!hold) piece_req = 1'b0;
        do_draw(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, piece_ack, 48'd0);
        chk({tag, "_ptype"}, piece_type, 48'd0);
        chk({tag, "_valid"}, next_valid, 48'd0);
        chk({tag, "_ntype"}, next_type, 48'd0);
        chk({tag, "_grid"}, next_block_data, 48'd0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_zero("rst");
        chk("rst_fb_valid", fb_valid, 48'd0);
        chk("rst_fb_grid", fb_grid, 48'd0);

        // First draw from 0xACE1: candidate 1 (O) is accepted on the first edge.
        n_rst = 1'b1;
        do_draw("first");
        chk("first_type_const", next_type, 48'd1);
        chk("first_grid_const", next_block_data, 48'h0001_B01B_0000);

        // Fallback instance: candidate 7 with MAX_RETRY=1 yields I after one cycle.
        chk("fb_valid", fb_valid, 48'd1);
        chk("fb_type", fb_ntype, 48'd0);
        chk("fb_grid", fb_grid, 48'h0000_006D_B000);

        for (int g = 0; g < 3; g++) begin
            seen = 7'h00;
            for (int k = 0; k < 7; k++) begin
                do_request(1'b0, "bag");
                seen[piece_type] = 1'b1;
            end
            chk("bag_perm", seen, 48'h7F);
        end

        for (int k = 0; k < 3; k++) begin
            do_request(1'b1, "hold");
        end
        piece_req = 1'b0;

        // Asynchronous reset landing between edges while in GEN.
        piece_req = 1'b1;
        @(negedge clk);
        chk("arst_pre_ack", piece_ack, 48'd1);
        piece_req = 1'b0;
        #2 n_rst = 1'b0;
        #1 chk_zero("arst");
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        do_draw("rst2");
        chk("rst2_type_const", next_type, 48'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: observed no completion, expected finish before 200000");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
